// File: rtl/hwce_job_scheduler.sv
// Job scheduler for the HWCE engine: queues convolution descriptors, configures and starts the
// engine per job, supervises it with a watchdog and reports done/error events.
module hwce_job_scheduler #(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned OG_W        = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [OG_W-1:0]  job_n_og_i,
    input  logic [2:0]       job_filter_size_i,
    input  logic [2:0]       job_zp_i,
    input  logic [15:0]      job_linebuf_len_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic [2:0]       filter_size_o,
    output logic [2:0]       zero_padding_o,
    output logic [15:0]      linebuf_length_o,
    output logic             engine_start_o,
    output logic             engine_clear_o,
    input  logic [3:0]       fsm_state_i,
    input  logic [OG_W-1:0]  n_og_i,
    output logic             busy_o,
    output logic             done_evt_o,
    output logic             err_evt_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] job_count_o
);

    localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int unsigned DESC_W = OG_W + 22;
    localparam logic [3:0] ENG_IDLE = 4'b0000;
    localparam logic [3:0] ENG_TERM = 4'b0110;
    localparam logic [1:0] ERR_NO_START = 2'b01;
    localparam logic [1:0] ERR_OG       = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    localparam logic [CNT_W-1:0] START_LIMIT = CNT_W'(15);
    localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W+1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_START, S_WAIT, S_RUN, S_CHK, S_DONE, S_ERR
    } state_e;

    state_e r_state, w_state_nxt;

    logic [DESC_W-1:0] r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_rdy_en;
    logic              w_full, w_empty, w_push, w_pop;
    logic [OG_W-1:0]   w_head_og;
    logic [2:0]        w_head_fs, w_head_zp;
    logic [15:0]       w_head_len;

    logic [OG_W-1:0]  r_n_og, r_last_og, r_prev_og, w_og_last;
    logic [3:0]       r_prev_state;
    logic             r_seen_term, r_cfg_cnt;
    logic [CNT_W-1:0] r_wdog, w_wdog_inc, r_job_cnt;
    logic [2:0]       r_fs, r_zp;
    logic [15:0]      r_len;
    logic [1:0]       r_err, w_err_val;
    logic             w_err_set, w_latch, w_eng_clear, w_change, w_timeout;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign job_ready_o = r_rdy_en & ~w_full;
    assign w_push      = job_valid_i & job_ready_o;
    assign {w_head_og, w_head_fs, w_head_zp, w_head_len} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {job_n_og_i, job_filter_size_i, job_zp_i, job_linebuf_len_i};
        end
    end

    // r_rdy_en keeps ready low for one cycle after clear is released
    always_ff @(posedge clk) begin
        if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_change   = (fsm_state_i != r_prev_state) || (n_og_i != r_prev_og);
    assign w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
    assign w_og_last  = r_n_og - OG_W'(1);
    // r_wdog counts cycles since the engine last changed, the change cycle being cycle 0
    assign w_timeout  = (timeout_i != '0) && !w_change && (r_wdog == timeout_i);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        w_err_set   = 1'b0;
        w_err_val   = 2'b00;
        w_eng_clear = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && fsm_state_i == ENG_IDLE) begin
                    w_pop = 1'b1;
                    if (w_head_og == '0) begin
                        w_err_set   = 1'b1;
                        w_err_val   = ERR_OG;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_CFG;
                    end
                end
            end
            S_CFG:   if (r_cfg_cnt) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (fsm_state_i != ENG_IDLE) begin
                    w_state_nxt = S_RUN;
                end else if (r_wdog == START_LIMIT) begin
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_NO_START;
                    w_state_nxt = S_ERR;
                end
            end
            S_RUN: begin
                if (w_timeout) begin
                    w_eng_clear = 1'b1;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TIMEOUT;
                    w_state_nxt = S_ERR;
                end else if (fsm_state_i == ENG_IDLE) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (r_seen_term && r_last_og == w_og_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_OG;
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_cfg_cnt    <= 1'b0;
            r_wdog       <= '0;
            r_prev_state <= '0;
            r_prev_og    <= '0;
            r_last_og    <= '0;
            r_seen_term  <= 1'b0;
            r_n_og       <= '0;
            r_fs         <= '0;
            r_zp         <= '0;
            r_len        <= '0;
            r_err        <= '0;
            r_job_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_state <= fsm_state_i;
            r_prev_og    <= n_og_i;
            r_cfg_cnt    <= (r_state == S_CFG) & ~r_cfg_cnt;
            if (w_latch) begin
                r_n_og <= w_head_og;
                r_fs   <= w_head_fs;
                r_zp   <= w_head_zp;
                r_len  <= w_head_len;
            end
            if (w_err_set) begin
                r_err <= w_err_val;
            end else if (r_state == S_START) begin
                r_err <= '0;
            end
            if (r_state == S_DONE || r_state == S_ERR) r_job_cnt <= r_job_cnt + 1'b1;
            case (r_state)
                S_START: r_wdog <= '0;
                S_WAIT:  r_wdog <= (fsm_state_i != ENG_IDLE) ? CNT_W'(1) : w_wdog_inc;
                S_RUN:   r_wdog <= w_change ? CNT_W'(1) : w_wdog_inc;
                default: r_wdog <= r_wdog;
            endcase
            if (r_state == S_START) begin
                r_last_og   <= '0;
                r_seen_term <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_last_og <= n_og_i;
                if (fsm_state_i == ENG_TERM) r_seen_term <= 1'b1;
            end
        end
    end

    assign filter_size_o    = r_fs;
    assign zero_padding_o   = r_zp;
    assign linebuf_length_o = r_len;
    assign engine_start_o   = (r_state == S_START);
    assign engine_clear_o   = w_eng_clear;
    assign busy_o           = (r_state != S_IDLE) || !w_empty;
    assign done_evt_o       = (r_state == S_DONE);
    assign err_evt_o        = (r_state == S_ERR);
    assign err_code_o       = r_err;
    assign job_count_o      = r_job_cnt;

endmodule

// File: tb/tb_hwce_job_scheduler.sv
// Self-checking bench for hwce_job_scheduler: behavioural engine model plus a scoreboard that
// predicts each job's outcome from its descriptor and the engine behaviour chosen for it.
module tb_hwce_job_scheduler;

    localparam int OG_W  = 8;
    localparam int CNT_W = 16;
    localparam logic [3:0] E_IDLE = 4'b0000, E_PLWL = 4'b1001, E_RUN = 4'b0011;
    localparam logic [3:0] E_CHG  = 4'b0010, E_TERM = 4'b0110;
    localparam int M_GOOD = 0, M_NOTERM = 1, M_SHORT = 2, M_IGNORE = 3, M_FREEZE = 4;

    typedef struct {
        int          n;
        logic [2:0]  fs;
        logic [2:0]  zp;
        logic [15:0] len;
        int          mode;
    } job_t;

    typedef struct {
        job_t       job;
        bit         exp_done;
        logic [1:0] exp_code;
    } vec_t;

    logic             clk = 1'b0;
    logic             clear;
    logic             job_valid_i;
    logic             job_ready_o;
    logic [OG_W-1:0]  job_n_og_i;
    logic [2:0]       job_filter_size_i;
    logic [2:0]       job_zp_i;
    logic [15:0]      job_linebuf_len_i;
    logic [CNT_W-1:0] timeout_i;
    logic [2:0]       filter_size_o;
    logic [2:0]       zero_padding_o;
    logic [15:0]      linebuf_length_o;
    logic             engine_start_o;
    logic             engine_clear_o;
    logic [3:0]       eng_state = E_IDLE;
    logic [OG_W-1:0]  eng_og = '0;
    logic             busy_o;
    logic             done_evt_o;
    logic             err_evt_o;
    logic [1:0]       err_code_o;
    logic [CNT_W-1:0] job_count_o;

    hwce_job_scheduler #(.QUEUE_DEPTH(2), .OG_W(OG_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .clear             (clear),
        .job_valid_i       (job_valid_i),
        .job_ready_o       (job_ready_o),
        .job_n_og_i        (job_n_og_i),
        .job_filter_size_i (job_filter_size_i),
        .job_zp_i          (job_zp_i),
        .job_linebuf_len_i (job_linebuf_len_i),
        .timeout_i         (timeout_i),
        .filter_size_o     (filter_size_o),
        .zero_padding_o    (zero_padding_o),
        .linebuf_length_o  (linebuf_length_o),
        .engine_start_o    (engine_start_o),
        .engine_clear_o    (engine_clear_o),
        .fsm_state_i       (eng_state),
        .n_og_i            (eng_og),
        .busy_o            (busy_o),
        .done_evt_o        (done_evt_o),
        .err_evt_o         (err_evt_o),
        .err_code_o        (err_code_o),
        .job_count_o       (job_count_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0, n_fail = 0;
    job_t model_q[$];
    int   exp_cnt = 0, n_events = 0, start_cyc = 0, end_cyc = -1, last_chg = 0;
    bit   mon_en = 0, active = 0, cnt_chk = 0, eng_abort = 0, last_done = 0;
    logic [1:0] last_code = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        check(name, longint'(cond), 1);
    endtask

    // Outcome predicted purely from descriptor and engine behaviour: 0 = done, else error code
    function automatic int exp_code(input job_t j);
        if (j.n == 0) return 2;
        case (j.mode)
            M_GOOD:   return 0;
            M_IGNORE: return 1;
            M_FREEZE: return 3;
            default:  return 2;
        endcase
    endfunction

    task automatic eng_step(input logic [3:0] st, input int og, input int hold);
        @(posedge clk);
        #1;
        if (st != eng_state || OG_W'(og) != eng_og) last_chg = cyc;
        eng_state = st;
        eng_og    = OG_W'(og);
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic play(input job_t j);
        int top;
        if (j.mode == M_IGNORE) return;
        if (j.mode == M_FREEZE) begin
            eng_step(E_PLWL, 0, 2);
            eng_step(E_RUN, 0, 2);
            for (int i = 0; i < 3000; i++) begin
                if (engine_clear_o || eng_abort) break;
                @(negedge clk);
            end
            eng_step(E_IDLE, 0, 1);
            return;
        end
        top = (j.mode == M_SHORT) ? j.n - 2 : j.n - 1;
        eng_step(E_PLWL, 0, 1 + int'($urandom_range(0, 2)));
        for (int g = 0; g <= top; g++) begin
            if (g > 0) eng_step(E_CHG, g, 1);
            eng_step(E_RUN, g, 1 + int'($urandom_range(0, 3)));
        end
        if (j.mode != M_NOTERM) eng_step(E_TERM, top, 2);
        eng_step(E_IDLE, top, 1);
    endtask

    initial begin : engine
        forever begin
            @(negedge clk);
            if (engine_start_o && model_q.size() > 0) play(model_q[0]);
        end
    end

    initial begin : monitor
        job_t j;
        int   code;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cnt_chk) begin
                    check("job_count", job_count_o, exp_cnt);
                    cnt_chk = 0;
                end
                if (engine_start_o) begin
                    check_true("start_has_job", model_q.size() > 0);
                    check_true("start_single", !active);
                    if (model_q.size() > 0) begin
                        j = model_q[0];
                        check_true("start_og_nonzero", j.n != 0);
                        check("start_filter_size", filter_size_o, j.fs);
                        check("start_zero_padding", zero_padding_o, j.zp);
                        check("start_linebuf_len", linebuf_length_o, j.len);
                        if (end_cyc >= 0) check_true("start_gap_ge4", cyc - end_cyc >= 4);
                    end
                    start_cyc = cyc;
                    active    = 1;
                end else if (active && model_q.size() > 0) begin
                    check("hold_filter_size", filter_size_o, model_q[0].fs);
                    check("hold_linebuf_len", linebuf_length_o, model_q[0].len);
                    check("busy_in_job", busy_o, 1);
                end
                if (engine_clear_o) begin
                    check_true("clear_expected", model_q.size() > 0 && timeout_i != 0 &&
                               model_q[0].mode == M_FREEZE);
                    check("timeout_latency", cyc - last_chg, timeout_i);
                end
                if (done_evt_o || err_evt_o) begin
                    check_true("event_expected", model_q.size() > 0);
                    if (model_q.size() > 0) begin
                        j    = model_q.pop_front();
                        code = exp_code(j);
                        check("evt_done", done_evt_o, code == 0);
                        check("evt_err", err_evt_o, code != 0);
                        check("evt_err_code", err_code_o, code);
                        if (code == 1) check("no_start_latency", cyc - start_cyc, 17);
                        exp_cnt++;
                        cnt_chk = 1;
                    end
                    last_done = done_evt_o;
                    last_code = err_code_o;
                    n_events++;
                    active  = 0;
                    end_cyc = cyc;
                end
            end
        end
    end

    task automatic push_job(input job_t j);
        bit ok = 0;
        @(posedge clk);
        #1;
        job_valid_i       = 1'b1;
        job_n_og_i        = OG_W'(j.n);
        job_filter_size_i = j.fs;
        job_zp_i          = j.zp;
        job_linebuf_len_i = j.len;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (job_ready_o) begin
                ok = 1;
                break;
            end
        end
        check_true("push_accepted", ok);
        if (ok) model_q.push_back(j);
        @(posedge clk);
        #1;
        job_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy_o && model_q.size() == 0 && eng_state == E_IDLE && !cnt_chk) begin
                ok = 1;
                break;
            end
        end
        check_true("drain_idle", ok);
        check("drain_job_count", job_count_o, exp_cnt);
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (engine_start_o) begin
                ok = 1;
                break;
            end
        end
        check_true("start_seen", ok);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, job_ready_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_start"}, engine_start_o, 0);
        check({tag, "_eng_clear"}, engine_clear_o, 0);
        check({tag, "_done"}, done_evt_o, 0);
        check({tag, "_err"}, err_evt_o, 0);
        check({tag, "_err_code"}, err_code_o, 0);
        check({tag, "_job_count"}, job_count_o, 0);
        check({tag, "_cfg"}, {filter_size_o, zero_padding_o, linebuf_length_o}, 0);
    endtask

    initial begin : main
        vec_t vecs[7];
        job_t j;
        int   ev0, r;
        bit   ok;

        vecs[0] = '{job: '{n: 3, fs: 3'd5, zp: 3'd0, len: 16'd32,  mode: M_GOOD},   exp_done: 1, exp_code: 2'b00};
        vecs[1] = '{job: '{n: 3, fs: 3'd3, zp: 3'd1, len: 16'd64,  mode: M_SHORT},  exp_done: 0, exp_code: 2'b10};
        vecs[2] = '{job: '{n: 2, fs: 3'd3, zp: 3'd7, len: 16'd100, mode: M_NOTERM}, exp_done: 0, exp_code: 2'b10};
        vecs[3] = '{job: '{n: 1, fs: 3'd5, zp: 3'd2, len: 16'd16,  mode: M_IGNORE}, exp_done: 0, exp_code: 2'b01};
        vecs[4] = '{job: '{n: 0, fs: 3'd3, zp: 3'd3, len: 16'd50,  mode: M_GOOD},   exp_done: 0, exp_code: 2'b10};
        vecs[5] = '{job: '{n: 4, fs: 3'd3, zp: 3'd4, len: 16'd200, mode: M_FREEZE}, exp_done: 0, exp_code: 2'b11};
        vecs[6] = '{job: '{n: 1, fs: 3'd5, zp: 3'd5, len: 16'd999, mode: M_GOOD},   exp_done: 1, exp_code: 2'b00};

        clear = 1'b1;
        job_valid_i = 1'b0;
        job_n_og_i = '0;
        job_filter_size_i = '0;
        job_zp_i = '0;
        job_linebuf_len_i = '0;
        timeout_i = CNT_W'(100);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("ready_after_reset_cycle0", job_ready_o, 0);
        @(negedge clk);
        check("ready_after_reset_cycle1", job_ready_o, 1);
        mon_en = 1;

        // Directed vectors, one job at a time
        for (int i = 0; i < 7; i++) begin
            ev0 = n_events;
            push_job(vecs[i].job);
            ok = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (n_events != ev0) begin
                    ok = 1;
                    break;
                end
            end
            check_true($sformatf("vec%0d_event", i), ok);
            check($sformatf("vec%0d_done", i), last_done, vecs[i].exp_done);
            check($sformatf("vec%0d_err_code", i), last_code, vecs[i].exp_code);
            wait_idle(500);
        end

        // Queue fills behind a running job; the third push must stall
        push_job('{n: 5, fs: 3'd5, zp: 3'd1, len: 16'd77, mode: M_GOOD});
        wait_start();
        push_job('{n: 2, fs: 3'd3, zp: 3'd2, len: 16'd11, mode: M_GOOD});
        push_job('{n: 3, fs: 3'd5, zp: 3'd3, len: 16'd22, mode: M_GOOD});
        @(negedge clk);
        check("ready_when_full", job_ready_o, 0);
        check("busy_when_full", busy_o, 1);
        push_job('{n: 1, fs: 3'd3, zp: 3'd6, len: 16'd33, mode: M_GOOD});
        wait_idle(800);

        // Randomised jobs against the scoreboard
        timeout_i = CNT_W'(40);
        for (int i = 0; i < 14; i++) begin
            j.n   = int'($urandom_range(0, 5));
            j.fs  = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd3;
            j.zp  = 3'($urandom_range(0, 7));
            j.len = 16'($urandom_range(0, 65535));
            r     = int'($urandom_range(0, 9));
            case (r)
                5:       j.mode = M_NOTERM;
                6:       j.mode = (j.n >= 2) ? M_SHORT : M_GOOD;
                7:       j.mode = M_IGNORE;
                8:       j.mode = M_FREEZE;
                default: j.mode = M_GOOD;
            endcase
            push_job(j);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(4000);

        // Clear in the middle of a run with a full queue
        timeout_i = '0;
        push_job('{n: 2, fs: 3'd5, zp: 3'd1, len: 16'd44, mode: M_FREEZE});
        wait_start();
        push_job('{n: 1, fs: 3'd3, zp: 3'd0, len: 16'd55, mode: M_GOOD});
        push_job('{n: 1, fs: 3'd3, zp: 3'd0, len: 16'd66, mode: M_GOOD});
        @(negedge clk);
        check("ready_full_before_clear", job_ready_o, 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        clear  = 1'b1;
        mon_en = 0;
        repeat (2) @(negedge clk);
        check_all_zero("mid_run_clear");
        @(posedge clk);
        #1;
        clear     = 1'b0;
        eng_abort = 1;
        model_q.delete();
        exp_cnt = 0;
        active  = 0;
        cnt_chk = 0;
        end_cyc = -1;
        @(negedge clk);
        check("ready_clear_drop_cycle0", job_ready_o, 0);
        @(negedge clk);
        check("ready_clear_drop_cycle1", job_ready_o, 1);
        check("busy_after_clear", busy_o, 0);
        for (int k = 0; k < 20 && eng_state != E_IDLE; k++) @(negedge clk);
        eng_abort = 0;
        mon_en    = 1;
        push_job('{n: 2, fs: 3'd5, zp: 3'd3, len: 16'd88, mode: M_GOOD});
        wait_idle(500);
        check("final_job_count", job_count_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
